// File: rtl/aes128_decrypt_iter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : aes128_decrypt_iter_if
//  Brief    : Job-in / plaintext-out handshake bundle for aes128_decrypt_iter.
//  Revision : 1.0  initial release
// ============================================================================
interface aes128_decrypt_iter_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] din;
    logic [127:0] k;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] dout;

    modport master (output in_valid, din, k, out_ready,
                    input  in_ready, out_valid, dout);
    modport slave  (input  in_valid, din, k, out_ready,
                    output in_ready, out_valid, dout);
endinterface
`default_nettype wire

// File: rtl/aes128_decrypt_iter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : aes128_decrypt_iter
//  Brief    : Iterative AES-128 inverse cipher, one round per clock, with
//             on-the-fly inverse key schedule and optional last-key cache.
//  Revision : 1.0  initial release
// ============================================================================
module aes128_decrypt_iter #(
    parameter int NR        = 10,
    parameter bit KEY_CACHE = 1'b1
) (
    input  wire logic            clk,
    input  wire logic            rst,
    aes128_decrypt_iter_if.slave bus
);
    localparam logic [3:0] c_last_rnd = 4'(NR);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_KEXP  = 3'd1,
        S_INIT  = 3'd2,
        S_ROUND = 3'd3,
        S_FINAL = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    generate
        if (NR != 10) begin : g_nr_check
            $error("aes128_decrypt_iter: NR must be 10");
        end
    endgenerate

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0).
    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] x2, x3, x12, x15, x240;
        x2   = gmul(x, x);
        x3   = gmul(x2, x);
        x12  = gmul(gmul(x3, x3), gmul(x3, x3));
        x15  = gmul(x12, x3);
        x240 = gmul(x15, x15);
        x240 = gmul(x240, x240);
        x240 = gmul(x240, x240);
        x240 = gmul(x240, x240);
        return gmul(gmul(x240, x12), x2);
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = ginv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return ginv({x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] key_f(input logic [31:0] w, input logic [7:0] rc);
        return {sbox(w[23:16]) ^ rc, sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic logic [127:0] fwd_expand(input logic [127:0] kin, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w0 = kin[127:96] ^ key_f(kin[31:0], rc);
        w1 = kin[95:64]  ^ w0;
        w2 = kin[63:32]  ^ w1;
        w3 = kin[31:0]   ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Walks the schedule backwards: rk_r -> rk_(r-1) using rcon of round r.
    function automatic logic [127:0] inv_expand(input logic [127:0] kin, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w3 = kin[31:0]  ^ kin[63:32];
        w2 = kin[63:32] ^ kin[95:64];
        w1 = kin[95:64] ^ kin[127:96];
        w0 = kin[127:96] ^ key_f(w3, rc);
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = inv_sbox(s[127-8*(4*((c-r+4)%4)+r) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
            o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
            o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
            o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
        return o;
    endfunction

    state_t       r_state;
    logic [3:0]   r_rnd;
    logic [127:0] r_st;
    logic [127:0] r_key;
    logic         r_in_ready;
    logic         r_out_valid;
    logic [127:0] r_dout;
    logic         r_cache_vld;
    logic [127:0] r_cache_k;
    logic [127:0] r_cache_rk10;

    logic [127:0] w_fwd_key;
    logic [127:0] w_inv_key;
    logic [127:0] w_shsub;
    logic         w_hit;

    assign w_fwd_key = fwd_expand(r_key, rcon(r_rnd));
    assign w_inv_key = inv_expand(r_key, rcon(r_rnd));
    assign w_shsub   = inv_shift_sub(r_st);

    generate
        if (KEY_CACHE) begin : g_cache
            assign w_hit = r_cache_vld && (bus.k == r_cache_k);
        end else begin : g_no_cache
            assign w_hit = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_rnd        <= 4'd0;
            r_st         <= '0;
            r_key        <= '0;
            r_in_ready   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_dout       <= '0;
            r_cache_vld  <= 1'b0;
            r_cache_k    <= '0;
            r_cache_rk10 <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid && r_in_ready) begin
                        r_st       <= bus.din;
                        r_in_ready <= 1'b0;
                        if (w_hit) begin
                            r_key   <= r_cache_rk10;
                            r_rnd   <= c_last_rnd;
                            r_state <= S_INIT;
                        end else begin
                            // Cache entry is rebuilt for this key once expansion finishes.
                            r_key       <= bus.k;
                            r_cache_k   <= bus.k;
                            r_cache_vld <= 1'b0;
                            r_rnd       <= 4'd1;
                            r_state     <= S_KEXP;
                        end
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                S_KEXP: begin
                    r_key <= w_fwd_key;
                    if (r_rnd == c_last_rnd) begin
                        r_cache_rk10 <= w_fwd_key;
                        r_cache_vld  <= KEY_CACHE;
                        r_state      <= S_INIT;
                    end else begin
                        r_rnd <= r_rnd + 4'd1;
                    end
                end
                S_INIT: begin
                    r_st    <= r_st ^ r_key;
                    r_key   <= w_inv_key;
                    r_rnd   <= c_last_rnd - 4'd1;
                    r_state <= S_ROUND;
                end
                S_ROUND: begin
                    r_st  <= inv_mix(w_shsub ^ r_key);
                    r_key <= w_inv_key;
                    r_rnd <= r_rnd - 4'd1;
                    if (r_rnd == 4'd1) r_state <= S_FINAL;
                end
                S_FINAL: begin
                    r_dout      <= w_shsub ^ r_key;
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.dout      = r_dout;
endmodule
`default_nettype wire

// File: tb/tb_aes128_decrypt_iter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_aes128_decrypt_iter
//  Brief    : Scoreboard bench for aes128_decrypt_iter using published AES-128
//             vectors; latency counted with the accept cycle as cycle 0.
//  Revision : 1.0  initial release
// ============================================================================
module tb_aes128_decrypt_iter;
    localparam logic [127:0] c_k_c1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] c_ct_c1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] c_pt_c1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] c_k_kf  = 128'h5468617473206d79204b756e67204675;
    localparam logic [127:0] c_ct_kf = 128'h29c3505f571420f6402299b31a02d73a;
    localparam logic [127:0] c_pt_kf = 128'h54776f204f6e65204e696e652054776f;
    localparam logic [127:0] c_k_b   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] c_ct_b  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] c_pt_b  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] c_ct_e1 = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    localparam logic [127:0] c_pt_e1 = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] c_ct_e2 = 128'hf5d3d58503b9699de785895a96fdbaaf;
    localparam logic [127:0] c_pt_e2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam int c_miss = 22;
    localparam int c_hit  = 12;

    typedef struct {
        logic [127:0] exp;
        int           lat;
        int           acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_mis = 0;
    bit   mon_seen = 1'b0;
    exp_t sb[$];

    aes128_decrypt_iter_if bus ();

    aes128_decrypt_iter #(.NR(10), .KEY_CACHE(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_mis++;
        $display("FAIL %s: got timeout expected handshake (cycle %0d)", name, cyc);
    endtask

    // Present a job; the accept edge is the posedge following the negedge where in_ready is seen.
    task automatic send(input logic [127:0] c, input logic [127:0] kk,
                        input logic [127:0] exp, input int lat);
        int n;
        n = 0;
        @(negedge clk);
        bus.din      = c;
        bus.k        = kk;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            fail_now("accept");
            bus.in_valid = 1'b0;
        end else begin
            sb.push_back('{exp, lat, cyc});
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            bus.din      = ~c;
            bus.k        = ~kk;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) fail_now("drain");
        @(negedge clk);
    endtask

    // Monitor: one scoreboard pop per presented plaintext.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                mon_seen = 1'b0;
            end else if (bus.out_valid && !mon_seen) begin
                mon_seen = 1'b1;
                if (sb.size() == 0) begin
                    chk("unexpected_output", {8'h0, bus.dout}, 136'h0);
                end else begin
                    e = sb.pop_front();
                    chk("dout", {8'h0, bus.dout}, {8'h0, e.exp});
                    chk("latency", 136'(cyc - e.acc), 136'(e.lat));
                end
            end else if (!bus.out_valid) begin
                mon_seen = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.din       = '0;
        bus.k         = '0;
        bus.out_ready = 1'b0;

        repeat (3) @(negedge clk);
        chk("reset_state", {6'h0, bus.in_ready, bus.out_valid, bus.dout}, 136'h0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 50; i++) begin
            chk("idle", {6'h0, bus.in_ready, bus.out_valid, bus.dout}, {6'h0, 1'b1, 1'b0, 128'h0});
            @(negedge clk);
        end

        bus.out_ready = 1'b1;
        send(c_ct_c1, c_k_c1, c_pt_c1, c_miss);
        send(c_ct_c1, c_k_c1, c_pt_c1, c_hit);
        send(c_ct_kf, c_k_kf, c_pt_kf, c_miss);
        send(c_ct_b,  c_k_b,  c_pt_b,  c_miss);
        send(c_ct_e1, c_k_b,  c_pt_e1, c_hit);
        send(c_ct_e2, c_k_b,  c_pt_e2, c_hit);
        send(c_ct_c1, c_k_c1, c_pt_c1, c_miss);
        drain();

        // Backpressure: output held, busy-time in_valid pulses must be ignored.
        bus.out_ready = 1'b0;
        send(c_ct_kf, c_k_kf, c_pt_kf, c_miss);
        begin
            int n;
            n = 0;
            while (!bus.out_valid && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (!bus.out_valid) fail_now("backpressure_wait");
        end
        for (int i = 0; i < 15; i++) begin
            chk("bp_hold", {6'h0, bus.in_ready, bus.out_valid, bus.dout}, {6'h0, 1'b0, 1'b1, c_pt_kf});
            bus.in_valid = i[0];
            bus.din      = c_ct_c1 ^ 128'(i);
            bus.k        = c_k_c1;
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release", {6'h0, bus.in_ready, bus.out_valid, bus.dout}, {6'h0, 1'b1, 1'b0, c_pt_kf});
        drain();

        // Reset during the 8th KEXP cycle aborts the job immediately.
        send(c_ct_c1, c_k_c1, c_pt_c1, c_miss);
        repeat (7) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("reset_abort", {6'h0, bus.in_ready, bus.out_valid, bus.dout}, 136'h0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        send(c_ct_c1, c_k_c1, c_pt_c1, c_miss);
        send(c_ct_c1, c_k_c1, c_pt_c1, c_hit);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
`default_nettype wire
